// File: rtl/fetch_stage_pkg.sv
// Shared constants for the minuteCore fetch stage: default widths, reset PC,
// FSM state encodings and the instruction stride.
package fetch_stage_pkg;
  localparam int unsigned ADDR_W_DEF   = 32;
  localparam int unsigned INSTR_W_DEF  = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int unsigned PC_STRIDE    = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: decode-side outputs, stall/flush controls and the
// instruction-memory read port. master = fetch stage, slave = its environment.
interface fetch_stage_if import fetch_stage_pkg::*; #(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned INSTR_W = INSTR_W_DEF
);
  logic [ADDR_W-1:0]  PC;
  logic [INSTR_W-1:0] instr;
  logic               pipeline_valid;
  logic               mem_rd_enable;
  logic [ADDR_W-1:0]  mem_rd_addr;
  logic               mem_rd_ready;
  logic [INSTR_W-1:0] mem_rd_data;
  logic               stall;
  logic               flush;
  logic [ADDR_W-1:0]  flush_addr;

  modport master (
    output PC, instr, pipeline_valid, mem_rd_enable, mem_rd_addr,
    input  mem_rd_ready, mem_rd_data, stall, flush, flush_addr
  );

  modport slave (
    input  PC, instr, pipeline_valid, mem_rd_enable, mem_rd_addr,
    output mem_rd_ready, mem_rd_data, stall, flush, flush_addr
  );
endinterface

// File: rtl/fetch_stage_skid_buf.sv
// One-entry {addr,data} holding register for a word that completes while decode
// is stalled. Clear wins over load, load wins over pop.
module fetch_skid_buf import fetch_stage_pkg::*; #(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_load,
  input  logic               i_pop,
  input  logic               i_clear,
  input  logic [ADDR_W-1:0]  i_addr,
  input  logic [INSTR_W-1:0] i_data,
  output logic               o_full,
  output logic [ADDR_W-1:0]  o_addr,
  output logic [INSTR_W-1:0] o_data
);
  logic               r_full;
  logic [ADDR_W-1:0]  r_addr;
  logic [INSTR_W-1:0] r_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_full <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else if (i_clear) begin
      r_full <= 1'b0;
    end else if (i_load) begin
      r_full <= 1'b1;
      r_addr <= i_addr;
      r_data <= i_data;
    end else if (i_pop) begin
      r_full <= 1'b0;
    end
  end

  assign o_full = r_full;
  assign o_addr = r_addr;
  assign o_data = r_data;
endmodule

// File: rtl/fetch_stage.sv
// minuteCore instruction fetch: one single-beat read at a time, stall skid buffer,
// flush redirect. Define FETCH_TRACE_EN for a simulation-only delivery trace.
module fetch_stage import fetch_stage_pkg::*; #(
  parameter int unsigned       ADDR_W   = ADDR_W_DEF,
  parameter int unsigned       INSTR_W  = INSTR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input logic           clk,
  input logic           reset,
  fetch_stage_if.master bus
);
  logic [1:0]         r_state;
  logic [ADDR_W-1:0]  r_fetch_ptr;
  logic [ADDR_W-1:0]  r_pc;
  logic [INSTR_W-1:0] r_instr;
  logic               r_valid;

  logic               w_accept;
  logic               w_deliver;
  logic               w_skid_full;
  logic [ADDR_W-1:0]  w_skid_addr;
  logic [INSTR_W-1:0] w_skid_data;
  logic [ADDR_W-1:0]  w_dlv_addr;
  logic [INSTR_W-1:0] w_dlv_data;

  // A flush in the same cycle as ready cancels the beat outright.
  assign w_accept  = (r_state == ST_REQ) && bus.mem_rd_ready && !bus.flush;
  // Skid and a fresh accept are exclusive: REQ is entered only with the skid empty.
  assign w_deliver = !bus.flush && !bus.stall && (w_skid_full || w_accept);
  assign w_dlv_addr = w_skid_full ? w_skid_addr : r_fetch_ptr;
  assign w_dlv_data = w_skid_full ? w_skid_data : bus.mem_rd_data;

  fetch_skid_buf #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) u_skid (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_accept && bus.stall),
    .i_pop   (w_skid_full && !bus.stall && !bus.flush),
    .i_clear (bus.flush),
    .i_addr  (r_fetch_ptr),
    .i_data  (bus.mem_rd_data),
    .o_full  (w_skid_full),
    .o_addr  (w_skid_addr),
    .o_data  (w_skid_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_fetch_ptr <= RESET_PC;
      r_pc        <= '0;
      r_instr     <= '0;
      r_valid     <= 1'b0;
    end else if (bus.flush) begin
      r_state     <= ST_IDLE;
      r_fetch_ptr <= bus.flush_addr;
      r_valid     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (!bus.stall && !w_skid_full) r_state <= ST_REQ;
        ST_REQ: begin
          if (bus.mem_rd_ready) begin
            r_state     <= ST_RESP;
            r_fetch_ptr <= r_fetch_ptr + ADDR_W'(PC_STRIDE);
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
      // Decode-facing outputs freeze entirely while stalled.
      if (!bus.stall) begin
        r_valid <= w_deliver;
        if (w_deliver) begin
          r_pc    <= w_dlv_addr;
          r_instr <= w_dlv_data;
        end
      end
    end
  end

  assign bus.mem_rd_enable  = (r_state == ST_REQ);
  assign bus.mem_rd_addr    = r_fetch_ptr;
  assign bus.PC             = r_pc;
  assign bus.instr          = r_instr;
  assign bus.pipeline_valid = r_valid;

`ifdef FETCH_TRACE_EN
  always @(posedge clk) begin
    if (reset && w_deliver) $display("FETCH PC=%h INSTR=%h", w_dlv_addr, w_dlv_data);
  end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed steps plus randomized stall/flush/ready
// traffic, compared against a transaction-level model of the fetch rules.
module tb_fetch_stage;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fetch_stage_if #(.ADDR_W(32), .INSTR_W(32)) bus ();

  fetch_stage #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // stimulus knobs
  logic        s_stall = 1'b0;
  logic        s_flush = 1'b0;
  logic [31:0] s_faddr = 32'h0;
  int          rdy_pct = 100;

  // reference model: request outstanding, one-cycle gap after a beat, skid as a queue
  logic        m_req, m_gap, m_valid;
  logic [31:0] m_ptr, m_pc, m_instr;
  logic [31:0] q_addr[$];
  logic [31:0] q_data[$];
  logic [31:0] log_pc[$];
  logic [31:0] log_instr[$];
  logic [31:0] exp_skid;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_req = 1'b0; m_gap = 1'b0; m_valid = 1'b0;
    m_ptr = 32'h0; m_pc = 32'h0; m_instr = 32'h0;
    q_addr.delete(); q_data.delete();
  endtask

  // One clock: drive inputs, advance the model, check outputs after the edge.
  task automatic cycle();
    logic rdy, got, dlv, was_empty;
    logic [31:0] data;
    check("mem_rd_enable", bus.mem_rd_enable, m_req);
    if (m_req) check("mem_rd_addr", bus.mem_rd_addr, m_ptr);
    rdy  = m_req ? (int'($urandom_range(99)) < rdy_pct) : ($urandom_range(1) == 1);
    data = (m_req && rdy) ? m_ptr + 32'h8000 : $urandom();
    bus.mem_rd_ready = rdy;
    bus.mem_rd_data  = data;
    bus.stall        = s_stall;
    bus.flush        = s_flush;
    bus.flush_addr   = s_faddr;
    dlv = 1'b0;
    if (s_flush) begin
      m_req = 1'b0; m_gap = 1'b0; m_valid = 1'b0; m_ptr = s_faddr;
      q_addr.delete(); q_data.delete();
    end else begin
      got = m_req && rdy;
      was_empty = (q_addr.size() == 0);
      if (!s_stall) begin
        if (!was_empty) begin
          m_pc = q_addr.pop_front(); m_instr = q_data.pop_front(); dlv = 1'b1;
        end else if (got) begin
          m_pc = m_ptr; m_instr = data; dlv = 1'b1;
        end
        m_valid = dlv;
      end else if (got) begin
        q_addr.push_back(m_ptr); q_data.push_back(data);
      end
      if (got) begin
        m_ptr = m_ptr + 32'd4; m_req = 1'b0; m_gap = 1'b1;
      end else if (m_gap) begin
        m_gap = 1'b0;
      end else if (!m_req && !s_stall && was_empty) begin
        m_req = 1'b1;
      end
    end
    @(posedge clk); #1;
    check("PC", bus.PC, m_pc);
    check("instr", bus.instr, m_instr);
    check("pipeline_valid", bus.pipeline_valid, m_valid);
    if (dlv) begin
      log_pc.push_back(m_pc);
      log_instr.push_back(m_instr);
      $display("deliver PC=%h instr=%h", m_pc, m_instr);
    end
  endtask

  initial begin
    bus.mem_rd_ready = 1'b0; bus.mem_rd_data = 32'h0;
    bus.stall = 1'b0; bus.flush = 1'b0; bus.flush_addr = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_enable", bus.mem_rd_enable, 1'b0);
    check("rst_valid", bus.pipeline_valid, 1'b0);
    check("rst_pc", bus.PC, 32'h0);
    check("rst_instr", bus.instr, 32'h0);
    @(negedge clk) reset = 1'b1;

    // free-run, zero-latency memory
    rdy_pct = 100;
    log_pc.delete(); log_instr.delete();
    repeat (9) cycle();
    check("run_pc0", (log_pc.size() > 0) ? log_pc[0] : 32'hDEAD_BEEF, 32'h0);
    check("run_instr0", (log_instr.size() > 0) ? log_instr[0] : 32'hDEAD_BEEF, 32'h8000);
    check("run_pc1", (log_pc.size() > 1) ? log_pc[1] : 32'hDEAD_BEEF, 32'h4);
    check("run_instr2", (log_instr.size() > 2) ? log_instr[2] : 32'hDEAD_BEEF, 32'h8008);

    // mid-stream flush to 4
    repeat (2) cycle();
    s_flush = 1'b1; s_faddr = 32'h4;
    cycle();
    check("flush_valid0", bus.pipeline_valid, 1'b0);
    s_flush = 1'b0;
    log_pc.delete(); log_instr.delete();
    repeat (6) cycle();
    check("flush_pc", (log_pc.size() > 0) ? log_pc[0] : 32'hDEAD_BEEF, 32'h4);
    check("flush_instr", (log_instr.size() > 0) ? log_instr[0] : 32'hDEAD_BEEF, 32'h8004);

    // stall while a request is pending; ready lands into the skid
    rdy_pct = 0;
    for (int k = 0; k < 10 && !m_req; k++) cycle();
    check("stall_req_pending", bus.mem_rd_enable, 1'b1);
    cycle();
    exp_skid = m_ptr;
    s_stall = 1'b1; rdy_pct = 100;
    cycle();
    repeat (3) cycle();
    check("stall_no_req", bus.mem_rd_enable, 1'b0);
    check("stall_valid_held", bus.pipeline_valid, 1'b0);
    s_stall = 1'b0;
    cycle();
    check("skid_valid", bus.pipeline_valid, 1'b1);
    check("skid_pc", bus.PC, exp_skid);
    check("skid_instr", bus.instr, exp_skid + 32'h8000);
    cycle();
    check("skid_pulse", bus.pipeline_valid, 1'b0);

    // stall and flush together: flush wins
    s_stall = 1'b1; s_flush = 1'b1; s_faddr = 32'h40;
    cycle();
    s_stall = 1'b0; s_flush = 1'b0;
    log_pc.delete(); log_instr.delete();
    repeat (6) cycle();
    check("sf_pc", (log_pc.size() > 0) ? log_pc[0] : 32'hDEAD_BEEF, 32'h40);
    check("sf_instr", (log_instr.size() > 0) ? log_instr[0] : 32'hDEAD_BEEF, 32'h8040);

    // address wrap at the top of memory
    s_flush = 1'b1; s_faddr = 32'hFFFF_FFFC;
    cycle();
    s_flush = 1'b0;
    log_pc.delete(); log_instr.delete();
    repeat (8) cycle();
    check("wrap_pc0", (log_pc.size() > 0) ? log_pc[0] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
    check("wrap_instr0", (log_instr.size() > 0) ? log_instr[0] : 32'hDEAD_BEEF, 32'h0000_7FFC);
    check("wrap_pc1", (log_pc.size() > 1) ? log_pc[1] : 32'hDEAD_BEEF, 32'h0);

    // randomized traffic
    rdy_pct = 50;
    for (int n = 0; n < 400; n++) begin
      s_stall = (int'($urandom_range(99)) < 25);
      s_flush = (int'($urandom_range(99)) < 6);
      case ($urandom_range(2))
        0:       s_faddr = {$urandom_range(32'h3FFF), 2'b00};
        1:       s_faddr = $urandom();
        default: s_faddr = 32'hFFFF_FFF8;
      endcase
      cycle();
    end
    s_stall = 1'b0; s_flush = 1'b0;

    // reset asserted while a request is outstanding
    rdy_pct = 0;
    for (int k = 0; k < 10 && !m_req; k++) cycle();
    check("rst_mid_req_pending", bus.mem_rd_enable, 1'b1);
    reset = 1'b0;
    #1;
    check("rst_mid_enable", bus.mem_rd_enable, 1'b0);
    check("rst_mid_valid", bus.pipeline_valid, 1'b0);
    check("rst_mid_pc", bus.PC, 32'h0);
    model_reset();
    @(negedge clk) reset = 1'b1;
    rdy_pct = 100;
    cycle();
    check("restart_enable", bus.mem_rd_enable, 1'b1);
    check("restart_addr", bus.mem_rd_addr, 32'h0);
    repeat (6) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
